// File: rtl/sdp_ram_rd_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdp_ram_rd_if
//  Description : AXI4 read-channel slave for a simple-dual-port RAM. It accepts
//                AR bursts, issues RAM reads, and returns data through an R FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdp_ram_rd_if #(
    parameter int DW          = 512,
    parameter int AW          = 10,
    parameter int RAM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          resetn,
    output logic [AW-1:0] ram_raddr,
    output logic          ram_re,
    input  logic [DW-1:0] ram_rdata,
    input  logic [31:0]   S_AXI_ARADDR,
    input  logic          S_AXI_ARVALID,
    input  logic [3:0]    S_AXI_ARID,
    input  logic [7:0]    S_AXI_ARLEN,
    input  logic [1:0]    S_AXI_ARBURST,
    output logic          S_AXI_ARREADY,
    output logic [DW-1:0] S_AXI_RDATA,
    output logic [3:0]    S_AXI_RID,
    output logic [1:0]    S_AXI_RRESP,
    output logic          S_AXI_RLAST,
    output logic          S_AXI_RVALID,
    input  logic          S_AXI_RREADY
);

    localparam int c_SHIFT = $clog2(DW / 8);
    localparam int c_PW    = $clog2(FIFO_DEPTH);
    localparam int c_CW    = $clog2(FIFO_DEPTH + 1);
    localparam int c_FW    = $clog2(RAM_LATENCY + 1);

    localparam logic [1:0] c_ST_INIT  = 2'd0;
    localparam logic [1:0] c_ST_IDLE  = 2'd1;
    localparam logic [1:0] c_ST_ISSUE = 2'd2;

    logic [1:0]      r_state;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_beats;
    logic [3:0]      r_id;

    // Tag layout: {valid, last, id[3:0]}
    logic [5:0]      r_tag [RAM_LATENCY];

    logic [DW-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [4:0]      r_fifo_meta [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic [31:0]     w_ar_word;
    logic [c_FW-1:0] w_in_flight;
    logic            w_credit;
    logic            w_issue;
    logic            w_issue_last;
    logic            w_push;
    logic            w_pop;
    logic            w_unused;

    assign w_ar_word = S_AXI_ARADDR >> c_SHIFT;
    assign w_unused  = ^{S_AXI_ARBURST, w_ar_word[31:AW]};

    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            w_in_flight = w_in_flight + c_FW'(r_tag[i][5]);
        end
    end

    // Counting every read not yet in the FIFO guarantees a free slot on landing.
    assign w_credit     = (int'(r_count) + int'(w_in_flight)) < FIFO_DEPTH;
    assign w_issue      = (r_state == c_ST_ISSUE) && w_credit;
    assign w_issue_last = w_issue && (r_beats == 8'd0);

    assign S_AXI_ARREADY = (r_state == c_ST_IDLE);
    assign ram_re        = w_issue;
    assign ram_raddr     = r_addr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_ST_INIT;
            r_addr  <= '0;
            r_beats <= '0;
            r_id    <= '0;
        end else begin
            case (r_state)
                c_ST_INIT: r_state <= c_ST_IDLE;
                c_ST_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        r_addr  <= w_ar_word[AW-1:0];
                        r_beats <= S_AXI_ARLEN;
                        r_id    <= S_AXI_ARID;
                        r_state <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    if (w_issue) begin
                        r_addr  <= r_addr + 1'b1;
                        r_beats <= r_beats - 1'b1;
                        if (r_beats == 8'd0) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: r_state <= c_ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= {w_issue, w_issue_last, r_id};
            for (int i = 1; i < RAM_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_push = r_tag[RAM_LATENCY-1][5];
    assign w_pop  = S_AXI_RVALID && S_AXI_RREADY;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= ram_rdata;
            r_fifo_meta[r_wr_ptr] <= r_tag[RAM_LATENCY-1][4:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset, so sideband outputs are qualified by RVALID.
    assign S_AXI_RVALID = (r_count != '0);
    assign S_AXI_RDATA  = r_fifo_data[r_rd_ptr];
    assign S_AXI_RID    = S_AXI_RVALID ? r_fifo_meta[r_rd_ptr][3:0] : 4'd0;
    assign S_AXI_RLAST  = S_AXI_RVALID && r_fifo_meta[r_rd_ptr][4];
    assign S_AXI_RRESP  = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_sdp_ram_rd_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdp_ram_rd_if
//  Description : Randomized scoreboard bench for sdp_ram_rd_if with a RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdp_ram_rd_if;

    localparam int DW          = 512;
    localparam int AW          = 10;
    localparam int RAM_LATENCY = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int WORDS       = 1 << AW;

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    id;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic [AW-1:0] ram_raddr;
    logic          ram_re;
    logic [DW-1:0] ram_rdata;
    logic [31:0]   S_AXI_ARADDR;
    logic          S_AXI_ARVALID;
    logic [3:0]    S_AXI_ARID;
    logic [7:0]    S_AXI_ARLEN;
    logic [1:0]    S_AXI_ARBURST;
    logic          S_AXI_ARREADY;
    logic [DW-1:0] S_AXI_RDATA;
    logic [3:0]    S_AXI_RID;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RLAST;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY;

    int            total = 0;
    int            bad   = 0;
    int            rr_mode = 0;
    beat_t         exp_q [$];
    logic [DW-1:0] mem [WORDS];
    logic [DW-1:0] rpipe [RAM_LATENCY];

    sdp_ram_rd_if #(
        .DW(DW), .AW(AW), .RAM_LATENCY(RAM_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .resetn(resetn),
        .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_rdata(ram_rdata),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RID(S_AXI_RID), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM with a fixed read latency
    always @(posedge clk) begin
        rpipe[0] <= ram_re ? mem[ram_raddr] : '0;
        for (int k = 1; k < RAM_LATENCY; k++) begin
            rpipe[k] <= rpipe[k-1];
        end
    end
    assign ram_rdata = rpipe[RAM_LATENCY-1];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // RREADY patterns: 0 always, 1 one-on/three-off, 2 random, 3 never
    initial begin
        int ph = 0;
        S_AXI_RREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       S_AXI_RREADY = 1'b1;
                1:       S_AXI_RREADY = (ph == 0);
                2:       S_AXI_RREADY = 1'($urandom_range(0, 1));
                default: S_AXI_RREADY = 1'b0;
            endcase
            ph = (ph + 1) % 4;
        end
    end

    // Monitor: scoreboard pops, stall stability, outstanding-read bound
    initial begin
        int            outst = 0;
        bit            prev_stall = 0;
        logic [DW-1:0] pd = '0;
        logic [3:0]    pid = '0;
        logic          pl = 1'b0;
        beat_t         e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                outst = 0;
                prev_stall = 0;
            end else begin
                if (ram_re) begin
                    outst++;
                    chk("credit_bound", DW'(outst <= FIFO_DEPTH), DW'(1));
                end
                if (prev_stall) begin
                    chk("stall_stable", DW'(S_AXI_RVALID && S_AXI_RDATA == pd &&
                        S_AXI_RID == pid && S_AXI_RLAST == pl), DW'(1));
                end
                if (S_AXI_RVALID && S_AXI_RREADY) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", DW'(1), DW'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdata", S_AXI_RDATA, e.data);
                        chk("rid", DW'(S_AXI_RID), DW'(e.id));
                        chk("rlast", DW'(S_AXI_RLAST), DW'(e.last));
                        chk("rresp", DW'(S_AXI_RRESP), DW'(0));
                    end
                    outst--;
                end
                prev_stall = S_AXI_RVALID && !S_AXI_RREADY;
                pd  = S_AXI_RDATA;
                pid = S_AXI_RID;
                pl  = S_AXI_RLAST;
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic ar_send(input logic [31:0] addr, input int len, input logic [3:0] id,
                           input bit keep);
        bit ok = 0;
        int unsigned w;
        S_AXI_ARADDR  = addr;
        S_AXI_ARLEN   = 8'(len);
        S_AXI_ARID    = id;
        S_AXI_ARBURST = 2'($urandom_range(0, 3));
        S_AXI_ARVALID = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (S_AXI_ARREADY) begin
                ok = 1;
                break;
            end
        end
        chk("ar_accept", DW'(ok), DW'(1));
        if (ok) begin
            w = addr >> $clog2(DW / 8);
            for (int i = 0; i <= len; i++) begin
                exp_q.push_back('{mem[(w + i) % WORDS], id, (i == len)});
            end
        end
        @(posedge clk);
        #1;
        if (!keep || !ok) S_AXI_ARVALID = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("drain", DW'(exp_q.size()), DW'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = {16{$urandom()}};
        end
        resetn = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_ARID = '0;
        S_AXI_ARLEN = '0; S_AXI_ARBURST = '0;
        #2;
        chk("rst_arready", DW'(S_AXI_ARREADY), DW'(0));
        chk("rst_rvalid", DW'(S_AXI_RVALID), DW'(0));
        chk("rst_rlast", DW'(S_AXI_RLAST), DW'(0));
        chk("rst_ram_re", DW'(ram_re), DW'(0));
        chk("rst_raddr", DW'(ram_raddr), DW'(0));
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("init_arready", DW'(S_AXI_ARREADY), DW'(0));
        @(negedge clk);
        chk("idle_arready", DW'(S_AXI_ARREADY), DW'(1));
        @(posedge clk);
        #1;

        // Single beat latency
        ar_send(32'h80, 0, 4'd5, 0);
        @(negedge clk);
        chk("t1_ram_re", DW'(ram_re), DW'(1));
        chk("t1_raddr", DW'(ram_raddr), DW'(2));
        @(negedge clk);
        chk("t2_arready", DW'(S_AXI_ARREADY), DW'(1));
        @(negedge clk);
        chk("t3_rvalid", DW'(S_AXI_RVALID), DW'(0));
        @(negedge clk);
        chk("t4_rvalid", DW'(S_AXI_RVALID), DW'(1));
        wait_drain();

        // Burst of 8: back-to-back reads and R beats
        ar_send(32'h0, 7, 4'd9, 0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("b8_ram_re", DW'(ram_re), DW'(i < 8));
            if (i < 8) chk("b8_raddr", DW'(ram_raddr), DW'(i));
            chk("b8_rvalid", DW'(S_AXI_RVALID), DW'(i >= 3));
        end
        wait_drain();

        // Backpressure
        rr_mode = 1;
        ar_send(32'h1000, 15, 4'd3, 0);
        wait_drain();

        // Address wrap
        rr_mode = 0;
        ar_send(32'(1023 << 6), 2, 4'd7, 0);
        wait_drain();

        // Back-to-back bursts with ARVALID held
        ar_send(32'h0, 3, 4'd1, 1);
        ar_send(32'h400, 1, 4'd2, 0);
        wait_drain();

        // Randomized bursts
        repeat (12) begin
            rr_mode = $urandom_range(0, 2);
            ar_send($urandom(), $urandom_range(0, 40), 4'($urandom_range(0, 15)), 0);
            if ($urandom_range(0, 1) == 1) wait_drain();
        end
        wait_drain();
        rr_mode = 0;
        ar_send($urandom(), 255, 4'hA, 0);
        wait_drain();

        // Reset mid-burst with R stalled
        rr_mode = 3;
        ar_send(32'h2000, 31, 4'd4, 0);
        repeat (5) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("mid_rst_rvalid", DW'(S_AXI_RVALID), DW'(0));
        chk("mid_rst_arready", DW'(S_AXI_ARREADY), DW'(0));
        chk("mid_rst_ram_re", DW'(ram_re), DW'(0));
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        rr_mode = 0;
        @(negedge clk);
        chk("rel_arready0", DW'(S_AXI_ARREADY), DW'(0));
        @(negedge clk);
        chk("rel_arready1", DW'(S_AXI_ARREADY), DW'(1));
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (S_AXI_RVALID) cnt++;
        end
        chk("no_stale_beats", DW'(cnt), DW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdp_ram_rd_if.md
Name: sdp_ram_rd_if

Overview:
AXI4 read-channel slave for a simple-dual-port RAM block: read-side companion of the AXI write front-end that fills the same RAM. Accepts AR bursts, drives the RAM read port (fixed read latency), and returns data on the R channel. A small output FIFO absorbs RREADY backpressure, so no RAM read is ever dropped.

Parameters:
DW, 512, data width in bits (RAM word = one AXI beat; power of 2, >= 8)
AW, 10, RAM word-address width
RAM_LATENCY, 2, cycles from ram_re to ram_rdata valid (>= 1)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >= RAM_LATENCY+1)

Ports:
clk  in  1  single clock; all logic on posedge
resetn  in  1  reset, asynchronous, active-low
ram_raddr  out  AW  RAM read word address
ram_re  out  1  RAM read enable, one-cycle pulse per word
ram_rdata  in  DW  RAM read data, valid RAM_LATENCY cycles after ram_re
S_AXI_ARADDR  in  32  byte address
S_AXI_ARVALID  in  1  AR valid
S_AXI_ARID  in  4  transaction ID
S_AXI_ARLEN  in  8  beats-1
S_AXI_ARBURST  in  2  ignored; always treated as INCR
S_AXI_ARREADY  out  1  AR ready
S_AXI_RDATA  out  DW  read data
S_AXI_RID  out  4  ID echoed from ARID
S_AXI_RRESP  out  2  always 0 (OKAY)
S_AXI_RLAST  out  1  final beat of burst
S_AXI_RVALID  out  1  R valid
S_AXI_RREADY  in  1  R ready

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. resetn low immediately clears the FSM, address/beat counters, in-flight pipeline and FIFO. Reset values: ARREADY=0, RVALID=0, RLAST=0, ram_re=0, ram_raddr=0. Reset mid-burst discards all outstanding beats; no R beats follow reset release until a new AR.
- FSM states: INIT, IDLE, ISSUE.
  - INIT: first clock after reset release, go to IDLE with ARREADY=1.
  - IDLE: ARREADY=1. On AR handshake, latch addr = ARADDR >> log2(DW/8) (truncated to AW bits), beats_left = ARLEN, id = ARID. Drop ARREADY and go to ISSUE.
  - ISSUE: issue one read per cycle when credit allows. Issue means ram_re=1, ram_raddr=addr, addr <= addr+1 (wraps modulo 2^AW), beats_left decrements. The issue that occurs with beats_left==0 is the last: go to IDLE, ARREADY=1 the next cycle.
- Credit rule: issue only if (fifo_count + in_flight) < FIFO_DEPTH. in_flight counts issued reads whose data has not yet landed. This guarantees the FIFO never overflows.
- Tag pipeline: a RAM_LATENCY-deep shift register carries {valid, last, id} alongside each read. When the tag emerges, ram_rdata is written to the FIFO with its last flag and id.
- R channel:
  - RDATA/RID/RLAST/RVALID come from the FIFO head; RVALID = FIFO non-empty.
  - Pop occurs on RVALID&RREADY.
  - A push and a pop in the same cycle leave the count unchanged.
  - RDATA/RID/RLAST are stable while RVALID=1 and RREADY=0.
- Latency, with RREADY held high: AR handshake in cycle T, first ram_re in T+1, first RVALID in T+RAM_LATENCY+2. Subsequent beats are back-to-back, with no bubbles inside a burst.
- Between bursts: exactly one cycle of ARREADY=1 in IDLE is required, so there is a minimum 1-cycle issue gap between bursts. R beats of consecutive bursts may still be contiguous.
- ARLEN=0 is a single beat with RLAST=1. ARLEN=255 gives 256 beats.
- Address wrap: an address past 2^AW-1 wraps to 0 with no error response.

Test Plan:
- Single beat, default params: ARADDR=0x80, ARLEN=0, ARID=5, RREADY=1 -> ram_raddr=2 in T+1; RVALID in T+4; RDATA=mem[2], RID=5, RLAST=1; ARREADY=1 again by T+2.
- Burst of 8: ARADDR=0x0, ARLEN=7, RREADY=1 -> 8 consecutive RVALID beats with RDATA=mem[0..7]; RLAST only on beat 8; ram_re high for 8 consecutive cycles.
- Backpressure: ARLEN=15, RREADY toggled 1-cycle on / 3-cycles off -> all 16 beats delivered in order, none lost or duplicated; fifo_count+in_flight never exceeds 4; RDATA stable while stalled.
- Wrap: ARADDR=(1023<<6), ARLEN=2 -> beats return mem[1023], mem[0], mem[1].
- Back-to-back bursts: AR(ID=1, addr 0, LEN=3) then AR(ID=2, addr 0x400, LEN=1) held valid -> 6 beats; RID 1,1,1,1,2,2; RLAST on beats 4 and 6.
- Reset mid-burst: ARLEN=31 with RREADY=0; assert resetn low after 5 cycles -> RVALID/ARREADY drop immediately; after release, ARREADY=1 one cycle later, and no stale R beats appear.
